// File: rtl/gcd_initiator_if.sv
// gcd_initiator_if: bundle of the three channels around gcd_initiator.
//   op_*   producer -> initiator operand channel (valid/ready)
//   eng_*  initiator <-> GCD engine start/done channel
//   res_*  initiator -> consumer result channel (valid/ready), plus err_sticky
// Handshake rule for op_* and res_*: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised, the sender holds the
// payload stable until that transfer. The receiver may change ready at any time.
// The engine channel instead holds start high from issue until the result is
// taken, then drops it for one cycle so the engine can return to idle.
interface gcd_initiator_if;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        eng_start;
    logic [7:0]  eng_a;
    logic [7:0]  eng_b;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [7:0]  res_a;
    logic [7:0]  res_b;
    logic [7:0]  res_cycles;
    logic        res_err;
    logic        err_sticky;

    modport master (
        input  op_valid, op_a, op_b, eng_done, eng_result, res_ready,
        output op_ready, eng_start, eng_a, eng_b,
        output res_valid, res_data, res_a, res_b, res_cycles, res_err, err_sticky
    );

    modport slave (
        output op_valid, op_a, op_b, eng_done, eng_result, res_ready,
        input  op_ready, eng_start, eng_a, eng_b,
        input  res_valid, res_data, res_a, res_b, res_cycles, res_err, err_sticky
    );
endinterface

// File: rtl/gcd_initiator.sv
// gcd_initiator: requester-side sequencer for the start/done GCD engine.
// Buffers operand pairs in a DEPTH-entry FIFO, issues them one at a time to the
// engine, and presents each result (or a timeout error) on a one-entry slot.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          gcd_initiator_if.master (operand, engine and result channels)
//   dbg_state_o  current FSM state for observation
module gcd_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    gcd_initiator_if.master  bus,
    output logic [2:0]       dbg_state_o
);
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_TOUT      = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_a_q [DEPTH];
    logic [7:0]      mem_b_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            op_ready_q;
    logic            push, pop;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic            start_q, start_d;
    logic [7:0]      eng_a_q, eng_b_q;
    logic            slot_free, load_ok, load_tout;
    logic            res_valid_q, res_err_q, err_sticky_q;
    logic [15:0]     res_data_q;
    logic [7:0]      res_a_q, res_b_q, res_cycles_q;

    // ---------------- operand FIFO ----------------
    assign push = bus.op_valid && op_ready_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.op_a;
            mem_b_q[wr_ptr_q] <= bus.op_b;
        end
    end

    // op_ready is the registered !full of the next count, so a pop can only
    // reopen the FIFO from the following cycle onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            op_ready_q <= (count_d != DEPTH_C);
        end
    end

    // ---------------- issue FSM ----------------
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // The slot can take a new result if empty or being drained this cycle.
    assign slot_free = !res_valid_q || bus.res_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        pop       = 1'b0;
        load_ok   = 1'b0;
        load_tout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && bus.eng_done) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // done still high here means the engine has not picked up
                // the request yet; keep counting.
                cnt_d = cnt_inc;
                if (cnt_inc == TIMEOUT_C)  state_d = S_TOUT;
                else if (!bus.eng_done)    state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.eng_done && slot_free) begin
                    load_ok = 1'b1;
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end else if (!bus.eng_done) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) state_d = S_TOUT;
                end
            end
            S_TOUT: begin
                if (slot_free) begin
                    load_tout = 1'b1;
                    start_d   = 1'b0;
                    state_d   = S_RELEASE;
                end
            end
            // One start-low cycle returns the engine from finished to idle.
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            eng_a_q <= '0;
            eng_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            if (pop) begin
                eng_a_q <= mem_a_q[rd_ptr_q];
                eng_b_q <= mem_b_q[rd_ptr_q];
            end
        end
    end

    // ---------------- result slot ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_a_q      <= '0;
            res_b_q      <= '0;
            res_cycles_q <= '0;
            res_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (load_ok || load_tout) begin
            res_valid_q  <= 1'b1;
            res_data_q   <= load_ok ? bus.eng_result : 16'd0;
            res_a_q      <= eng_a_q;
            res_b_q      <= eng_b_q;
            res_cycles_q <= cnt_q;
            res_err_q    <= load_tout;
            if (load_tout) err_sticky_q <= 1'b1;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q  <= 1'b0;
        end
    end

    assign bus.op_ready   = op_ready_q;
    assign bus.eng_start  = start_q;
    assign bus.eng_a      = eng_a_q;
    assign bus.eng_b      = eng_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_a      = res_a_q;
    assign bus.res_b      = res_b_q;
    assign bus.res_cycles = res_cycles_q;
    assign bus.res_err    = res_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign dbg_state_o    = state_q;
endmodule
